// File: rtl/data_ram_io.sv
// Data-side memory responder: word RAM with combinational read and clocked write,
// plus an I/O window holding a byte TX FIFO, a status register and a cycle counter.
module data_ram_io #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        re,
    input  logic [31:0] raddr,
    output logic [31:0] rdata,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    output logic [7:0]  io_data,
    output logic        io_valid,
    input  logic        io_ready,
    output logic        err
);

    localparam int unsigned WORDS  = 1 << ADDR_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [1:0] OFF_TX     = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;

    // Storage and state
    logic [31:0]      mem [0:WORDS-1];
    logic [7:0]       fifo_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [31:0]      cycle;

    // Decode
    logic              rd_act;
    logic              wr_act;
    logic              rd_ram;
    logic              wr_ram;
    logic              rd_io;
    logic              wr_io;
    logic              rd_illegal;
    logic              wr_illegal;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              bypass;
    logic              addr_lsb_unused;

    assign rd_act  = ce & re;
    assign wr_act  = ce & we;
    assign rd_ram  = (raddr[31:ADDR_W+2] == '0);
    assign wr_ram  = (waddr[31:ADDR_W+2] == '0);
    assign rd_io   = (raddr[31:4] == IO_BASE[31:4]);
    assign wr_io   = (waddr[31:4] == IO_BASE[31:4]);
    assign rd_idx  = raddr[ADDR_W+1:2];
    assign wr_idx  = waddr[ADDR_W+1:2];
    assign rd_illegal = rd_act & ~rd_ram & ~rd_io;
    assign wr_illegal = wr_act & ~wr_ram & ~wr_io;
    assign bypass  = wr_act & wr_ram & (wr_idx == rd_idx);
    assign addr_lsb_unused = ^{raddr[1:0], waddr[1:0]};

    // FIFO control
    logic full;
    logic push_req;
    logic pop;
    logic push_ok;
    logic drop;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign io_valid = (count != '0);
    assign pop      = io_valid & io_ready;
    assign push_req = wr_act & wr_io & (waddr[3:2] == OFF_TX);
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign io_data  = io_valid ? fifo_mem[rptr] : 8'h00;

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && wr_act && wr_ram) begin
            mem[wr_idx] <= wdata;
        end
    end

    // FIFO storage; only the occupied region is ever observed
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            fifo_mem[wptr] <= wdata[7:0];
        end
    end

    // Pointers, occupancy, sticky flags and the cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
            cycle <= '0;
        end else begin
            cycle <= cycle + 32'd1;
            if (push_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
            if (rd_illegal || wr_illegal) begin
                err <= 1'b1;
            end
        end
    end

    // Read mux: RAM with same-word write bypass, then the I/O registers
    always_comb begin
        rdata = '0;
        if (rd_act) begin
            if (rd_ram) begin
                rdata = bypass ? wdata : mem[rd_idx];
            end else if (rd_io) begin
                case (raddr[3:2])
                    OFF_STATUS: rdata = {23'b0, ovf, full, 7'(count)};
                    OFF_CYCLE:  rdata = cycle;
                    default:    rdata = '0;
                endcase
            end
        end
    end

endmodule
